// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package memory_arbiter_pkg;

    localparam int DEF_ADDR_W = 28;
    localparam int DEF_DATA_W = 128;

    localparam logic PORT_D = 1'b0;
    localparam logic PORT_I = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        COMPLETE
    } arb_state_e;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } mem_op_e;

endpackage

// File: rtl/memory_arbiter_rr.sv
// Two-way round-robin pick between the data and instruction ports, remembering
// which port completed last so a tie goes to the other one.
module memory_arbiter_rr
    import memory_arbiter_pkg::*;
(
    input  logic CLK,
    input  logic RESET,
    input  logic req_d,
    input  logic req_i,
    input  logic update,
    input  logic served,
    output logic grant_valid,
    output logic grant
);

    logic last_served;

    // Starting from I means the data port wins the first tie after reset.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            last_served <= PORT_I;
        end else if (update) begin
            last_served <= served;
        end
    end

    always_comb begin
        grant_valid = req_d | req_i;
        if (req_d && req_i) begin
            grant = (last_served == PORT_D) ? PORT_I : PORT_D;
        end else if (req_i) begin
            grant = PORT_I;
        end else begin
            grant = PORT_D;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates a data cache and an instruction cache onto one blocking memory
// port: one access in flight, round-robin grant, sticky timeout flag.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 1024
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              D_READ,
    input  logic              D_WRITE,
    input  logic [ADDR_W-1:0] D_ADDRESS,
    input  logic [DATA_W-1:0] D_WRITEDATA,
    output logic [DATA_W-1:0] D_READDATA,
    output logic              D_BUSYWAIT,
    input  logic              I_READ,
    input  logic [ADDR_W-1:0] I_ADDRESS,
    output logic [DATA_W-1:0] I_READDATA,
    output logic              I_BUSYWAIT,
    output logic              MEM_READ,
    output logic              MEM_WRITE,
    output logic [ADDR_W-1:0] MEM_ADDRESS,
    output logic [DATA_W-1:0] MEM_WRITEDATA,
    input  logic [DATA_W-1:0] MEM_READDATA,
    input  logic              MEM_BUSYWAIT,
    output logic              ERROR
);

    localparam int               CNT_W      = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STALL_MAX  = CNT_W'(TIMEOUT);

    arb_state_e        state, state_next;
    logic              grant_q;
    mem_op_e           op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] d_rdata_q, i_rdata_q;
    logic [CNT_W-1:0]  stall_cnt;
    logic              error_q;

    logic d_pending, i_pending;
    logic grant_valid, grant;
    logic accept, capture, expire;

    assign d_pending = D_READ | D_WRITE;
    assign i_pending = I_READ;

    memory_arbiter_rr u_rr (
        .CLK         (CLK),
        .RESET       (RESET),
        .req_d       (d_pending),
        .req_i       (i_pending),
        .update      (state == COMPLETE),
        .served      (grant_q),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no branch
        // can leave one unassigned and infer a latch.
        state_next = state;
        accept     = 1'b0;
        capture    = 1'b0;
        expire     = 1'b0;
        MEM_READ   = 1'b0;
        MEM_WRITE  = 1'b0;
        D_BUSYWAIT = d_pending;
        I_BUSYWAIT = i_pending;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    accept     = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                MEM_READ   = (op_q == OP_READ);
                MEM_WRITE  = (op_q == OP_WRITE);
                state_next = WAIT;
            end
            WAIT: begin
                MEM_READ  = (op_q == OP_READ);
                MEM_WRITE = (op_q == OP_WRITE);
                if (!MEM_BUSYWAIT) begin
                    capture    = (op_q == OP_READ);
                    state_next = COMPLETE;
                end else if (stall_cnt >= STALL_LAST) begin
                    // This stall cycle reaches TIMEOUT: give up, data untouched.
                    expire     = 1'b1;
                    state_next = COMPLETE;
                end
            end
            COMPLETE: begin
                if (grant_q == PORT_D) begin
                    D_BUSYWAIT = 1'b0;
                end else begin
                    I_BUSYWAIT = 1'b0;
                end
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= IDLE;
            grant_q   <= PORT_D;
            op_q      <= OP_READ;
            addr_q    <= '0;
            wdata_q   <= '0;
            stall_cnt <= '0;
            error_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values, independent of statement order.
            state <= state_next;
            if (accept) begin
                grant_q   <= grant;
                stall_cnt <= '0;
                if (grant == PORT_D) begin
                    addr_q  <= D_ADDRESS;
                    wdata_q <= D_WRITEDATA;
                    op_q    <= D_WRITE ? OP_WRITE : OP_READ;
                end else begin
                    addr_q  <= I_ADDRESS;
                    wdata_q <= '0;
                    op_q    <= OP_READ;
                end
            end else if (state == WAIT && stall_cnt != STALL_MAX) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (expire) begin
                error_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            d_rdata_q <= '0;
            i_rdata_q <= '0;
        end else if (capture) begin
            if (grant_q == PORT_D) begin
                d_rdata_q <= MEM_READDATA;
            end else begin
                i_rdata_q <= MEM_READDATA;
            end
        end
    end

    assign MEM_ADDRESS   = addr_q;
    assign MEM_WRITEDATA = wdata_q;
    assign D_READDATA    = d_rdata_q;
    assign I_READDATA    = i_rdata_q;
    assign ERROR         = error_q;

endmodule
